code_memory_arbiter: RTL and testbench
======================================

// Module: code_memory_arbiter
// PURPOSE
// - Shares the single-port synchronous .text memory between instruction fetch (I) and data load (D) requesters.
// - Per-port req/grant handshake, range/alignment check against the .text window, address translation to a word index.
// - One access outstanding at a time; read-only port, .text writes are not routed here.
// - Sits between the core fetch/load paths and the text memory macro.
// PARAMETERS
// - BEGINNING_TEXT  32'h0040_0000  first byte address of .text window
// - END_TEXT        32'h0040_FFFC  last word address of .text window (inclusive)
// - TEXT_WIDTH      16             byte-address bits of memory; word index = offset[TEXT_WIDTH-1:2]
// - MEM_LATENCY     1              clock edges from address presented to iMemData valid (1..3)
// - STARVE_LIMIT    4              consecutive I-port losses before I wins forcibly (1..15)
// PORTS
// - iCLK      in   1             system clock
// - iRST      in   1             asynchronous reset, active-high
// - iIReq     in   1             I-port request; held with iIAddr stable until oIGnt
// - iIAddr    in   32            I-port byte address
// - oIGnt     out  1             I-port accept pulse (one cycle)
// - oIValid   out  1             I-port response valid (one cycle)
// - oIData    out  32            I-port read data, held until next I response
// - oIErr     out  1             I-port fault (out of window or misaligned), qualified by oIValid
// - iDReq/iDAddr/oDGnt/oDValid/oDData/oDErr  same as I-port, for data loads
// - oMemAddr  out  TEXT_WIDTH-2  word index to text memory
// - oMemRd    out  1             memory read strobe
// - iMemData  in   32            text memory read data
// BEHAVIOUR
// - FSM: IDLE -> WAIT -> RESP -> IDLE. Reset to IDLE; all outputs 0, oIData/oDData = 0, starve count = 0.
// - IDLE, cycle N: if any req, pick winner; grant pulse combinational in N; winner addr registered at edge ending N.
// - Winner: D beats I, unless starve count == STARVE_LIMIT, then I wins. Count++ (saturating) when I req loses; cleared when I wins or I not requesting.
// - Legal = addr in [BEGINNING_TEXT, END_TEXT] and addr[1:0]==0; offset = addr - BEGINNING_TEXT (32-bit unsigned).
// - Legal: oMemRd=1, oMemAddr=offset[TEXT_WIDTH-1:2] from N+1 through N+MEM_LATENCY; capture iMemData at edge ending N+MEM_LATENCY.
// - Illegal: no oMemRd; WAIT still runs MEM_LATENCY cycles (fixed latency); data=0, err=1.
// - RESP: winner's oXValid=1 in cycle N+MEM_LATENCY+1 only; other port's valid stays 0.
// - Next grant earliest in cycle N+MEM_LATENCY+2 (IDLE). Throughput 1 per MEM_LATENCY+2 cycles.
// - Req dropped before grant: no grant, no response. Req held past grant: treated as a new request in next IDLE.
// - Address 32'hFFFF_FFFC and addr < BEGINNING_TEXT: illegal, no wrap into window.
// - iRST mid-access: immediate return to IDLE, in-flight response discarded, no valid issued.
// CONFIGURATION
// - CODEMEM_ARB_RR_EN defined: round-robin; last winner gets lowest priority on simultaneous requests; starve counter removed; STARVE_LIMIT ignored.
// - Undefined: D priority with I starvation guard as above.
// TESTING
// - Reset, I reads 0x0040_0008, MEM_LATENCY=1, mem word 2 = 0xDEAD_BEEF -> oIGnt cyc N, oMemAddr=2, oIValid cyc N+2, oIData=0xDEAD_BEEF, oIErr=0.
// - Both req every cycle, STARVE_LIMIT=4 -> D granted 4 times, 5th grant to I, then D again; RR_EN build alternates D,I,D,I.
// - I addr 0x0040_0002, D addr 0x0000_0000, 0x0041_0000 -> err=1, data=0, oMemRd never asserted, valid still at N+MEM_LATENCY+1.
// - Boundaries 0x0040_0000 and 0x0040_FFFC -> oMemAddr 0 and 0x3FFF, err=0.
// - iRST pulsed in WAIT -> no oXValid, oMemRd=0, next request served normally with fresh latency.
// - MEM_LATENCY=3 sweep with random req -> every grant matched by exactly one valid at N+4, data equals memory model.

Source files
------------

// File: rtl/code_memory_arbiter.sv
// Arbitrates the single-port .text memory between instruction fetch (I) and data load (D) ports.
// Optional build macro CODEMEM_ARB_RR_EN selects round-robin instead of D priority with I guard.
module code_memory_arbiter #(
  parameter logic [31:0] BEGINNING_TEXT = 32'h0040_0000,
  parameter logic [31:0] END_TEXT       = 32'h0040_FFFC,
  parameter int unsigned TEXT_WIDTH     = 16,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iIReq,
  input  logic [31:0]           iIAddr,
  output logic                  oIGnt,
  output logic                  oIValid,
  output logic [31:0]           oIData,
  output logic                  oIErr,
  input  logic                  iDReq,
  input  logic [31:0]           iDAddr,
  output logic                  oDGnt,
  output logic                  oDValid,
  output logic [31:0]           oDData,
  output logic                  oDErr,
  output logic [TEXT_WIDTH-3:0] oMemAddr,
  output logic                  oMemRd,
  input  logic [31:0]           iMemData
);

  localparam logic [1:0] LastCnt = 2'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                r_state, w_state_d;
  logic [1:0]            r_cnt, w_cnt_d;
  logic                  r_owner_d;
  logic                  r_legal;
  logic [TEXT_WIDTH-3:0] r_widx;
  logic [31:0]           r_idata, r_ddata;
  logic                  r_ierr, r_derr;

  logic                  w_pick_d;
  logic                  w_any_req;
  logic [31:0]           w_addr, w_offset;
  logic                  w_legal;
  logic [TEXT_WIDTH-3:0] w_widx;
  logic                  w_unused_bits;
  logic                  w_capture;

  assign w_any_req = iIReq | iDReq;

`ifdef CODEMEM_ARB_RR_EN
  logic r_last_d, w_last_d;

  // Last winner takes the lowest priority when both ports ask together.
  always_comb begin
    w_pick_d = iDReq;
    if (iIReq && iDReq) w_pick_d = ~r_last_d;
    w_last_d = r_last_d;
    if (r_state == StIdle && w_any_req) w_last_d = w_pick_d;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_last_d <= 1'b0;
    else      r_last_d <= w_last_d;
  end
`else
  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  logic [3:0] r_starve, w_starve_d;

  always_comb begin
    w_pick_d   = iDReq && !(iIReq && r_starve == StarveLim);
    w_starve_d = r_starve;
    if (!iIReq) begin
      w_starve_d = '0;
    end else if (r_state == StIdle) begin
      if (!w_pick_d)                   w_starve_d = '0;
      else if (r_starve != StarveLim)  w_starve_d = r_starve + 4'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_starve <= '0;
    else      r_starve <= w_starve_d;
  end
`endif

  assign oDGnt = (r_state == StIdle) && w_pick_d;
  assign oIGnt = (r_state == StIdle) && iIReq && !w_pick_d;

  // Subtraction is 32-bit unsigned; the explicit range test stops wrap-around aliasing.
  assign w_addr        = w_pick_d ? iDAddr : iIAddr;
  assign w_offset      = w_addr - BEGINNING_TEXT;
  assign w_legal       = (w_addr >= BEGINNING_TEXT) && (w_addr <= END_TEXT) &&
                         (w_addr[1:0] == 2'b00);
  assign w_widx        = w_offset[TEXT_WIDTH-1:2];
  assign w_unused_bits = ^{w_offset[31:TEXT_WIDTH], w_offset[1:0]};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d = StWait;
          w_cnt_d   = '0;
        end
      end
      StWait: begin
        if (r_cnt == LastCnt) w_state_d = StResp;
        else                  w_cnt_d   = r_cnt + 2'd1;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_capture = (r_state == StWait) && (r_cnt == LastCnt);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_owner_d <= 1'b0;
      r_legal   <= 1'b0;
      r_widx    <= '0;
      r_idata   <= '0;
      r_ddata   <= '0;
      r_ierr    <= 1'b0;
      r_derr    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (r_state == StIdle && w_any_req) begin
        r_owner_d <= w_pick_d;
        r_legal   <= w_legal;
        r_widx    <= w_widx;
      end
      if (w_capture) begin
        if (r_owner_d) begin
          r_ddata <= r_legal ? iMemData : 32'h0;
          r_derr  <= ~r_legal;
        end else begin
          r_idata <= r_legal ? iMemData : 32'h0;
          r_ierr  <= ~r_legal;
        end
      end
    end
  end

  // Illegal accesses still sit out the full latency but never strobe the memory.
  assign oMemRd   = (r_state == StWait) && r_legal;
  assign oMemAddr = oMemRd ? r_widx : '0;
  assign oIValid  = (r_state == StResp) && !r_owner_d;
  assign oDValid  = (r_state == StResp) && r_owner_d;
  assign oIData   = r_idata;
  assign oDData   = r_ddata;
  assign oIErr    = r_ierr;
  assign oDErr    = r_derr;

endmodule

// File: tb/tb_code_memory_arbiter.sv
// Directed bench for code_memory_arbiter: latency-1 instance for directed vectors,
// latency-3 instance for a random-request scoreboard sweep.
module tb_code_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];

  logic        i_req1 = 0, d_req1 = 0, gi1, gd1, vi1, vd1, ie1, de1, rd1;
  logic [31:0] i_addr1 = 0, d_addr1 = 0, id1, dd1, mdata1;
  logic [13:0] maddr1;
  logic        i_req3 = 0, d_req3 = 0, gi3, gd3, vi3, vd3, ie3, de3, rd3;
  logic [31:0] i_addr3 = 0, d_addr3 = 0, id3, dd3, mdata3;
  logic [13:0] maddr3;

  // Poison value makes a capture outside the read window visible.
  assign mdata1 = rd1 ? mem[maddr1] : 32'hBAD0_BAD0;
  assign mdata3 = rd3 ? mem[maddr3] : 32'hBAD0_BAD0;

  code_memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .iCLK(clk), .iRST(rst),
    .iIReq(i_req1), .iIAddr(i_addr1), .oIGnt(gi1), .oIValid(vi1), .oIData(id1), .oIErr(ie1),
    .iDReq(d_req1), .iDAddr(d_addr1), .oDGnt(gd1), .oDValid(vd1), .oDData(dd1), .oDErr(de1),
    .oMemAddr(maddr1), .oMemRd(rd1), .iMemData(mdata1)
  );

  code_memory_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .iCLK(clk), .iRST(rst),
    .iIReq(i_req3), .iIAddr(i_addr3), .oIGnt(gi3), .oIValid(vi3), .oIData(id3), .oIErr(ie3),
    .iDReq(d_req3), .iDAddr(d_addr3), .oDGnt(gd3), .oDValid(vd3), .oDData(dd3), .oDErr(de3),
    .oMemAddr(maddr3), .oMemRd(rd3), .iMemData(mdata3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h0040_0000;
    if (a >= 32'h0040_0000 && a <= 32'h0040_FFFC && a[1:0] == 2'b00)
      return {1'b0, mem[off[15:2]]};
    return {1'b1, 32'h0};
  endfunction

  // Single-port transaction on the latency-1 instance; grant in N, read in N+1, valid in N+2.
  task automatic txn1(input string tag, input bit use_d, input logic [31:0] addr,
                      input logic [31:0] exp_data, input bit exp_err, input bit exp_rd,
                      input logic [13:0] exp_maddr);
    @(posedge clk); #1;
    if (use_d) begin d_req1 = 1; d_addr1 = addr; end
    else       begin i_req1 = 1; i_addr1 = addr; end
    @(negedge clk);
    chk({tag, "_gnt"}, 33'({gi1, gd1}), use_d ? 33'd1 : 33'd2);
    @(posedge clk); #1;
    i_req1 = 0; d_req1 = 0;
    @(negedge clk);
    chk({tag, "_rd"}, 33'(rd1), 33'(exp_rd));
    chk({tag, "_maddr"}, 33'(maddr1), 33'(exp_maddr));
    chk({tag, "_early"}, 33'({vi1, vd1}), 33'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 33'({vi1, vd1}), use_d ? 33'd1 : 33'd2);
    chk({tag, "_resp"}, use_d ? {de1, dd1} : {ie1, id1}, {exp_err, exp_data});
  endtask

  logic [31:0] tbl [8];
  bit          got_d [6];
  bit          exp_d [6];
  int          ng;

  initial begin
    mem[0]      = 32'h1111_0000;
    mem[1]      = 32'h0BAD_F00D;
    mem[2]      = 32'hDEAD_BEEF;
    mem[14'h3FFF] = 32'h2222_3FFF;
    tbl = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_FFFC,
            32'h0040_0002, 32'h0000_0000, 32'h0041_0000, 32'hFFFF_FFFC};
`ifdef CODEMEM_ARB_RR_EN
    exp_d = '{1, 0, 1, 0, 1, 0};
`else
    exp_d = '{1, 1, 1, 1, 0, 1};
`endif

    repeat (2) @(negedge clk);
    chk("rst_ctl", 33'({gi1, gd1, vi1, vd1, ie1, de1, rd1}), 33'd0);
    chk("rst_idata", 33'(id1), 33'd0);
    chk("rst_ddata", 33'(dd1), 33'd0);
    chk("rst_maddr", 33'(maddr1), 33'd0);
    @(posedge clk); #1 rst = 0;

    txn1("i_word2", 0, 32'h0040_0008, 32'hDEAD_BEEF, 0, 1, 14'd2);
    txn1("d_word1", 1, 32'h0040_0004, 32'h0BAD_F00D, 0, 1, 14'd1);
    txn1("lo_bound", 0, 32'h0040_0000, 32'h1111_0000, 0, 1, 14'd0);
    txn1("hi_bound", 1, 32'h0040_FFFC, 32'h2222_3FFF, 0, 1, 14'h3FFF);
    txn1("i_misal", 0, 32'h0040_0002, 32'h0, 1, 0, 14'd0);
    txn1("d_below", 1, 32'h0000_0000, 32'h0, 1, 0, 14'd0);
    txn1("d_above", 1, 32'h0041_0000, 32'h0, 1, 0, 14'd0);
    txn1("i_wrap", 0, 32'hFFFF_FFFC, 32'h0, 1, 0, 14'd0);

    // Reset pulsed while the access is in WAIT.
    @(posedge clk); #1;
    i_req1 = 1; i_addr1 = 32'h0040_0004;
    @(negedge clk);
    chk("mrst_gnt", 33'(gi1), 33'd1);
    @(posedge clk); #1;
    i_req1 = 0;
    chk("mrst_rd_pre", 33'(rd1), 33'd1);
    #2 rst = 1;
    #1 chk("mrst_rd_post", 33'(rd1), 33'd0);
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mrst_novalid", 33'({vi1, vd1}), 33'd0);
    end
    txn1("post_rst", 0, 32'h0040_0008, 32'hDEAD_BEEF, 0, 1, 14'd2);

    // Both ports requesting continuously.
    @(posedge clk); #1;
    i_req1 = 1; d_req1 = 1; i_addr1 = 32'h0040_0000; d_addr1 = 32'h0040_0004;
    ng = 0;
    for (int k = 0; k < 40 && ng < 6; k++) begin
      @(negedge clk);
      if (gi1 || gd1) begin
        chk("arb_onegnt", 33'(gi1 & gd1), 33'd0);
        got_d[ng] = gd1;
        ng++;
      end
    end
    @(posedge clk); #1;
    i_req1 = 0; d_req1 = 0;
    chk("arb_count", 33'(ng), 33'd6);
    for (int j = 0; j < 6; j++) chk($sformatf("arb_win%0d", j), 33'(got_d[j]), 33'(exp_d[j]));
    repeat (4) @(posedge clk);

    // Latency-3 random sweep against the scoreboard.
    begin
      int          c = 0;
      int          pend_cyc = 0;
      bit          pend = 0, pend_d = 0, gi_s = 0, gd_s = 0;
      logic [32:0] pend_exp = '0;
      for (int k = 0; k < 306; k++) begin
        @(posedge clk); #1;
        if (k >= 300) begin
          i_req3 = 0; d_req3 = 0;
        end else begin
          if (gi_s || !i_req3) begin
            i_req3 = ($urandom_range(0, 2) == 0); i_addr3 = tbl[$urandom_range(0, 7)];
          end
          if (gd_s || !d_req3) begin
            d_req3 = ($urandom_range(0, 2) == 0); d_addr3 = tbl[$urandom_range(0, 7)];
          end
        end
        @(negedge clk);
        c++;
        if (pend && c == pend_cyc) begin
          chk("sw_valid", 33'({vi3, vd3}), pend_d ? 33'd1 : 33'd2);
          chk("sw_resp", pend_d ? {de3, dd3} : {ie3, id3}, pend_exp);
          pend = 0;
        end else begin
          chk("sw_novalid", 33'({vi3, vd3}), 33'd0);
        end
        gi_s = gi3; gd_s = gd3;
        if (gi3 || gd3) begin
          chk("sw_onegnt", 33'(gi3 & gd3), 33'd0);
          pend     = 1;
          pend_cyc = c + 4;
          pend_d   = gd3;
          pend_exp = model(gd3 ? d_addr3 : i_addr3);
        end
      end
      chk("sw_drained", 33'(pend), 33'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
